// File: rtl/insn_memory_pkg.sv
// Shared defaults for the instruction-memory responder: instruction/address widths
// and response buffer sizing used as parameter defaults by insn_memory.
package insn_memory_pkg;

  localparam int LEN_INSN_DEF  = 32;
  localparam int LEN_IADDR_DEF = 10;

  // Three entries cover the landing word, the in-flight read and one more accept,
  // which is what one request per cycle needs; two is the smallest working size.
  localparam int BUF_DEPTH_DEF = 3;
  localparam int BUF_DEPTH_MIN = 2;

endpackage

// File: rtl/insn_resp_fifo.sv
// Response buffer for insn_memory: DEPTH x WIDTH circular FIFO with push/pop/count.
// The head reads as zero whenever the buffer is empty.
module insn_resp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 42,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? slots[rd_ptr] : '0;

endmodule

// File: rtl/insn_memory.sv
// Instruction-memory responder: synchronous-read RAM behind a valid/stall request
// channel, answering through a credit-gated response FIFO. Define INSN_MEM_WRITE_EN
// to add a program-load write port; otherwise the array is a ROM loaded from INIT_FILE.
//
// Handshake (both channels): a word transfers at a rising clk edge when valid is high
// and stall is low. A requester holds valid and address steady while stalled.
module insn_memory
  import insn_memory_pkg::*;
#(
  parameter int    LEN_INSN  = LEN_INSN_DEF,
  parameter int    LEN_IADDR = LEN_IADDR_DEF,
  parameter int    BUF_DEPTH = BUF_DEPTH_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_stall_o,
  input  logic [LEN_IADDR-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_stall_i,
  output logic [LEN_INSN-1:0]  resp_insn_o,
  output logic [LEN_IADDR-1:0] resp_addr_o
`ifdef INSN_MEM_WRITE_EN
  ,
  input  logic                 wr_en_i,
  input  logic [LEN_IADDR-1:0] wr_addr_i,
  input  logic [LEN_INSN-1:0]  wr_data_i
`endif
);

  localparam int WORDS = 1 << LEN_IADDR;
  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam int EW    = LEN_INSN + LEN_IADDR;

  logic [LEN_INSN-1:0]  mem [WORDS];
  logic [LEN_INSN-1:0]  rd_insn;
  logic [LEN_IADDR-1:0] rd_addr;
  logic                 inflight;
  logic                 accept;
  logic                 pop;
  logic [CW-1:0]        count;
  logic [CW:0]          credit;
  logic [EW-1:0]        head;

  // Credit counts the in-flight read so a landing word always finds a free slot;
  // it depends only on registered state, never on resp_stall_i.
  assign credit      = {1'b0, count} + (CW + 1)'(inflight);
  assign req_stall_o = rst || (credit >= (CW + 1)'(BUF_DEPTH));
  assign accept      = req_valid_i && !req_stall_o;

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_insn <= mem[req_addr_i];
      rd_addr <= req_addr_i;
    end
  end

`ifdef INSN_MEM_WRITE_EN
  // Same-address read in the same cycle samples the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
    end
  end

  assign resp_valid_o = (count != '0);
  assign pop          = resp_valid_o && !resp_stall_i;

  insn_resp_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data({rd_insn, rd_addr}),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign resp_insn_o = head[EW-1:LEN_IADDR];
  assign resp_addr_o = head[LEN_IADDR-1:0];

endmodule

// File: tb/tb_insn_memory.sv
// Self-checking bench for insn_memory: scoreboard of {insn, addr} words pushed on
// accepted requests and popped on delivered responses.
module tb_insn_memory;

  localparam int IW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 3;
  localparam int WORDS = 1 << AW;
  localparam int SW    = IW + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_stall;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_stall = 1'b0;
  logic [IW-1:0] resp_insn;
  logic [AW-1:0] resp_addr;
`ifdef INSN_MEM_WRITE_EN
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [IW-1:0] wr_data = '0;
`endif

  insn_memory #(
    .LEN_INSN (IW),
    .LEN_IADDR(AW),
    .BUF_DEPTH(DEPTH),
    .INIT_FILE("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_stall_o (req_stall),
    .req_addr_i  (req_addr),
    .resp_valid_o(resp_valid),
    .resp_stall_i(resp_stall),
    .resp_insn_o (resp_insn),
    .resp_addr_o (resp_addr)
`ifdef INSN_MEM_WRITE_EN
    ,
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            cyc = 0;
  int            t0 = 0;
  logic [SW-1:0] exp_q[$];
  int            pop_cyc[$];
  logic [IW-1:0] model_mem [WORDS];
  logic [SW-1:0] exp_word;
  logic [SW-1:0] prev_head = '0;
  bit            prev_held = 1'b0;
  bit            rand_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_stall) begin
      #1;
      resp_stall = ($urandom_range(0, 2) == 0);
    end
  end

  // A word may only land when the buffer has room or is popped the same edge.
  always @(posedge clk) begin
    if (!rst && dut.inflight && !(resp_valid && !resp_stall)) begin
      assert (int'(dut.count) < DEPTH)
        else $error("FAIL overflow: word landed into a full buffer");
    end
  end

  // Monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_held = 1'b0;
    end else begin
      if (prev_held) check("hold", {resp_insn, resp_addr}, prev_head);
      if (resp_valid && !resp_stall) begin
        if (exp_q.size() == 0) begin
          check("spurious", {resp_insn, resp_addr}, '1);
        end else begin
          exp_word = exp_q.pop_front();
          check("resp", {resp_insn, resp_addr}, exp_word);
        end
        pop_cyc.push_back(cyc);
      end
      prev_held = resp_valid && resp_stall;
      prev_head = {resp_insn, resp_addr};
      if (req_valid && !req_stall) exp_q.push_back({model_mem[req_addr], req_addr});
`ifdef INSN_MEM_WRITE_EN
      if (wr_en) model_mem[wr_addr] = wr_data;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until accepted; leaves valid high so streams can run back-to-back.
  task automatic send(input logic [AW-1:0] a);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!req_stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < WORDS; i++) model_mem[i] = $urandom;
    model_mem[0]         = 32'h11;
    model_mem[1]         = 32'h22;
    model_mem[2]         = 32'h33;
    model_mem[3]         = 32'h44;
    model_mem[WORDS - 1] = 32'hCAFE_03FF;
    for (int i = 0; i < WORDS; i++) dut.mem[i] = model_mem[i];

    // 1: reset then idle
    rst = 1'b1;
    repeat (3) tick();
    check("rst_stall", req_stall, 1);
    check("rst_valid", resp_valid, 0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_valid", resp_valid, 0);
    check("idle_stall", req_stall, 0);
    check("idle_insn", resp_insn, 0);
    check("idle_addr", resp_addr, 0);
    tick();

    // 2: back-to-back stream, no downstream stall
    pop_cyc.delete();
    send(0);
    t0 = cyc;
    send(1);
    send(2);
    send(3);
    req_valid = 1'b0;
    drain();
    check("t2_pops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      check("t2_first", pop_cyc[0] - t0, 1);
      check("t2_last", pop_cyc[3] - t0, 4);
    end

    // 3: downstream stall fills the credit, then release
    resp_stall = 1'b1;
    send(0);
    send(1);
    send(2);
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_stall", req_stall, 1);
    check("t3_valid", resp_valid, 1);
    check("t3_head", resp_insn, 32'h11);
    repeat (3) begin
      @(negedge clk);
      check("t3_hold_stall", req_stall, 1);
    end
    tick();
    pop_cyc.delete();
    resp_stall = 1'b0;
    send(3);
    req_valid = 1'b0;
    drain();
    check("t3_pops", pop_cyc.size(), 4);

    // 4: address wrap
    send(AW'(WORDS - 1));
    send(0);
    req_valid = 1'b0;
    drain();

    // 5: reset with two buffered words and one read in flight
    resp_stall = 1'b1;
    send(0);
    send(1);
    send(2);
    req_valid = 1'b0;
    check("t5_pre_count", dut.count, 2);
    check("t5_pre_inflight", dut.inflight, 1);
    rst = 1'b1;
    tick();
    check("t5_valid", resp_valid, 0);
    check("t5_count", dut.count, 0);
    check("t5_insn", resp_insn, 0);
    check("t5_addr", resp_addr, 0);
    rst = 1'b0;
    resp_stall = 1'b0;
    tick();
    pop_cyc.delete();
    send(1);
    req_valid = 1'b0;
    drain();
    repeat (3) tick();
    check("t5_pops", pop_cyc.size(), 1);

    // Random addresses, gaps and downstream stalls
    rand_stall = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send(AW'($urandom_range(0, WORDS - 1)));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    req_valid = 1'b0;
    rand_stall = 1'b0;
    tick();
    resp_stall = 1'b0;
    drain();

`ifdef INSN_MEM_WRITE_EN
    // 6: read-first on same-address write, then re-read
    wr_en   = 1'b1;
    wr_addr = 5;
    wr_data = 32'hDEAD;
    send(5);
    wr_en     = 1'b0;
    req_valid = 1'b0;
    drain();
    send(5);
    req_valid = 1'b0;
    drain();
    check("t6_model", model_mem[5], 32'hDEAD);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
